// File: rtl/cpld_link_scheduler_pkg.sv
// Frame layout, nav bit positions and scheduler state shared by the CPLD link block.
// Pure definitions: no logic, no latency, no flow control.
package cpld_link_pkg;
  localparam int FRAME_BITS = 16;
  localparam int LED_LSB    = 0;
  localparam int SEG_LSB    = 8;
  localparam int NAV_U      = 8;
  localparam int NAV_D      = 9;
  localparam int NAV_L      = 10;
  localparam int NAV_R      = 11;
  localparam int NAV_SEL    = 12;

  typedef enum logic {WAIT_SYNC = 1'b0, RUN = 1'b1} state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cpld_link_scheduler_if.sv
// Display requester bus: level req plus frame words in, one-cycle grant pulses out.
// Requesters hold req and req_data until their gnt pulse; no other backpressure.
interface cpld_link_scheduler_if import cpld_link_pkg::*; #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]            req;
  logic [FRAME_BITS*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]            gnt;

  modport master (output req, output req_data, input gnt);
  modport slave  (input req, input req_data, output gnt);
endinterface

// File: rtl/cpld_link_scheduler_rr_arbiter.sv
// Round-robin pick starting one past the previous winner; combinational, zero latency.
// No backpressure: o_found is low when nobody requests.
module rr_arbiter import cpld_link_pkg::*; #(
  parameter int N_REQ = 2,
  localparam int IW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last_winner,
  output logic [IW-1:0]    o_winner,
  output logic             o_found
);
  logic [IW-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      w_idx = IW'((int'(i_last_winner) + off) % N_REQ);
      if (!o_found && i_req[w_idx]) begin
        o_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end
endmodule

// File: rtl/cpld_link_scheduler.sv
// Serial CPLD link owner: one round-robin grant per 16-bit frame, word shifted out next frame; RX frame and nav published.
// Pins registered 1 clk after the counter; grant/rx_valid 1 clk after frame end; NAV_DEBOUNCE_EN adds nav debounce.
module cpld_link_scheduler import cpld_link_pkg::*; #(
  parameter int CLK_DIV_LOG2 = 12,
  parameter int N_REQ        = 2,
  parameter int DEBOUNCE_FRM = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  cpld_link_scheduler_if.slave  bus,
  input  logic                  i_cpld_miso,
  output logic                  o_cpld_mosi,
  output logic                  o_cpld_clk,
  output logic                  o_cpld_load,
  output logic [FRAME_BITS-1:0] o_rx_frame,
  output logic                  o_rx_valid,
  output logic [4:0]            o_nav
);
  localparam int CW = CLK_DIV_LOG2 + 5;
  localparam int IW = idx_width(N_REQ);

  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_nreq
    $error("N_REQ must be 2..4");
  end
  if (CLK_DIV_LOG2 < 1 || DEBOUNCE_FRM < 1) begin : g_bad_div
    $error("CLK_DIV_LOG2 and DEBOUNCE_FRM must be at least 1");
  end

  logic [CW-1:0]         r_cnt;
  logic [FRAME_BITS-1:0] r_tx_word;
  logic [FRAME_BITS-1:0] r_rx_sh;
  logic [FRAME_BITS-1:0] r_rx_frame;
  logic [IW-1:0]         r_last_winner;
  logic [N_REQ-1:0]      r_gnt;
  logic                  r_rx_valid;
  logic                  r_cpld_clk;
  logic                  r_mosi;
  logic                  r_load;
  logic [4:0]            r_nav;
  state_t                r_state;

  logic [3:0]            w_bit_idx;
  logic                  w_boundary;
  logic [IW-1:0]         w_winner;
  logic                  w_found;
  logic [FRAME_BITS-1:0] w_req_words [N_REQ];

  assign w_bit_idx  = r_cnt[CW-1 -: 4];
  assign w_boundary = &r_cnt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign w_req_words[g] = bus.req_data[FRAME_BITS*g +: FRAME_BITS];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req         (bus.req),
    .i_last_winner (r_last_winner),
    .o_winner      (w_winner),
    .o_found       (w_found)
  );

  // The first frame after reset only aligns the CPLD; arbitration starts at its end boundary's successor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_tx_word     <= '0;
      r_rx_sh       <= '0;
      r_rx_frame    <= '0;
      r_last_winner <= IW'(N_REQ - 1);
      r_gnt         <= '0;
      r_rx_valid    <= 1'b0;
      r_cpld_clk    <= 1'b0;
      r_mosi        <= 1'b0;
      r_load        <= 1'b0;
      r_state       <= WAIT_SYNC;
    end else begin
      r_cnt      <= r_cnt + CW'(1);
      r_cpld_clk <= r_cnt[CLK_DIV_LOG2];
      r_mosi     <= r_tx_word[w_bit_idx];
      r_load     <= (w_bit_idx == 4'hF);
      r_gnt      <= '0;
      r_rx_valid <= 1'b0;
      if (r_cpld_clk && (r_cnt[CLK_DIV_LOG2-1:0] == '0)) begin
        r_rx_sh[w_bit_idx] <= i_cpld_miso;
      end
      if (w_boundary) begin
        r_rx_frame <= r_rx_sh;
        r_rx_valid <= 1'b1;
        case (r_state)
          WAIT_SYNC: r_state <= RUN;
          RUN: begin
            if (w_found) begin
              r_tx_word       <= w_req_words[w_winner];
              r_gnt[w_winner] <= 1'b1;
              r_last_winner   <= w_winner;
            end
          end
        endcase
      end
    end
  end

`ifdef NAV_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_FRM + 1);
  logic [DW-1:0] r_db_cnt [5];

  // Each bit counts consecutive frames disagreeing with the published value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nav <= '0;
      for (int k = 0; k < 5; k++) r_db_cnt[k] <= '0;
    end else if (r_rx_valid) begin
      for (int k = 0; k < 5; k++) begin
        if (r_rx_frame[NAV_U+k] == r_nav[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DW'(DEBOUNCE_FRM - 1)) begin
          r_nav[k]    <= ~r_nav[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) r_nav <= '0;
    else if (r_rx_valid) r_nav <= r_rx_frame[NAV_SEL:NAV_U];
  end
`endif

  assign bus.gnt     = r_gnt;
  assign o_cpld_mosi = r_mosi;
  assign o_cpld_clk  = r_cpld_clk;
  assign o_cpld_load = r_load;
  assign o_rx_frame  = r_rx_frame;
  assign o_rx_valid  = r_rx_valid;
  assign o_nav       = r_nav;
endmodule

// File: tb/tb_cpld_link_scheduler.sv
// Directed bench for cpld_link_scheduler at CLK_DIV_LOG2=2 (bit = 8 clk, frame = 128 clk).
// Cycle c counts negedges since reset release; during cycle c the DUT counter holds c mod 128.
`timescale 1ns/1ps
module tb_cpld_link_scheduler;
  localparam int N_REQ = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miso = 1'b0;
  logic        mosi, cclk, load, rx_valid;
  logic [15:0] rx_frame;
  logic [4:0]  nav;
  logic [15:0] miso_pat = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  cpld_link_scheduler_if #(.N_REQ(N_REQ)) bus();

  cpld_link_scheduler #(.CLK_DIV_LOG2(2), .N_REQ(N_REQ), .DEBOUNCE_FRM(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .i_cpld_miso (miso),
    .o_cpld_mosi (mosi),
    .o_cpld_clk  (cclk),
    .o_cpld_load (load),
    .o_rx_frame  (rx_frame),
    .o_rx_valid  (rx_valid),
    .o_nav       (nav)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    miso = miso_pat[4'((cyc % 128) / 8)];
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic set_pat(input logic [15:0] p);
    miso_pat = p;
    miso = miso_pat[4'((cyc % 128) / 8)];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    miso = miso_pat[0];
  endtask

  task automatic read_word(input int start, output logic [15:0] w);
    w = '0;
    for (int b = 0; b < 16; b++) begin
      goto(start + b*8 + 4);
      w[b] = mosi;
    end
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.req_data = '0;
    set_pat(16'h0000);
    do_reset();
    n_checks++;
    if ({mosi, cclk, load} !== 3'b000) $display("FAIL reset_pins: got %b expected 000", {mosi, cclk, load});
    else n_pass++;
    n_checks++;
    if ({bus.gnt, rx_valid} !== 3'b000) $display("FAIL reset_gnt_valid: got %b expected 000", {bus.gnt, rx_valid});
    else n_pass++;
    n_checks++;
    if ({rx_frame, nav} !== 21'h0) $display("FAIL reset_rx_nav: got %h expected 0", {rx_frame, nav});
    else n_pass++;
  endtask

  task automatic test_idle();
    int mosi_ones = 0, loads = 0, gnts = 0, valids = 0;
    logic l120 = 1'b0, l121 = 1'b0, l128 = 1'b0, l129 = 1'b0, c4 = 1'b0, c5 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (mosi !== 1'b0) mosi_ones++;
      if (load === 1'b1) loads++;
      if (bus.gnt !== 2'b00) gnts++;
      if (rx_valid === 1'b1) valids++;
      if (cyc == 4) c4 = cclk;
      if (cyc == 5) c5 = cclk;
      if (cyc == 120) l120 = load;
      if (cyc == 121) l121 = load;
      if (cyc == 128) l128 = load;
      if (cyc == 129) l129 = load;
    end
    n_checks++;
    if (mosi_ones !== 0) $display("FAIL idle_mosi: got %0d nonzero bits expected 0", mosi_ones);
    else n_pass++;
    n_checks++;
    if (loads !== 16) $display("FAIL idle_load_count: got %0d expected 16", loads);
    else n_pass++;
    n_checks++;
    if ({l120, l121, l128, l129} !== 4'b0110) $display("FAIL idle_load_edges: got %b expected 0110", {l120, l121, l128, l129});
    else n_pass++;
    n_checks++;
    if ({c4, c5} !== 2'b01) $display("FAIL idle_cpld_clk: got %b expected 01", {c4, c5});
    else n_pass++;
    n_checks++;
    if (gnts !== 0) $display("FAIL idle_gnt: got %0d grants expected 0", gnts);
    else n_pass++;
    n_checks++;
    if (valids !== 2) $display("FAIL idle_rx_valid: got %0d pulses expected 2", valids);
    else n_pass++;
  endtask

  task automatic test_single_grant();
    int gc = -1;
    logic [1:0] gv = 2'b00;
    logic [0:15] exp_seq;
    logic [0:15] got_seq;
    logic [15:0] w;
    exp_seq = 16'b1100_0011_1010_0101;
    got_seq = '0;
    bus.req = 2'b01;
    bus.req_data = {16'h0000, 16'hA5C3};
    for (int i = 0; i < 200 && gc < 0; i++) begin
      step();
      if (bus.gnt !== 2'b00) begin
        gc = cyc;
        gv = bus.gnt;
      end
    end
    bus.req = 2'b00;
    n_checks++;
    if (gc !== 384) $display("FAIL grant_cycle: got %0d expected 384", gc);
    else n_pass++;
    n_checks++;
    if (gv !== 2'b01) $display("FAIL grant_value: got %b expected 01", gv);
    else n_pass++;
    step();
    n_checks++;
    if (bus.gnt !== 2'b00) $display("FAIL grant_pulse_width: got %b expected 00", bus.gnt);
    else n_pass++;
    for (int b = 0; b < 16; b++) begin
      goto(384 + b*8 + 4);
      got_seq[b] = mosi;
    end
    n_checks++;
    if (got_seq !== exp_seq) $display("FAIL mosi_sequence: got %b expected %b", got_seq, exp_seq);
    else n_pass++;
    read_word(512, w);
    n_checks++;
    if (w !== 16'hA5C3) $display("FAIL display_persists: got %h expected a5c3", w);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int at [5] = '{128, 256, 384, 512, 640};
    logic [1:0] exp_g [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] w;
    do_reset();
    bus.req = 2'b11;
    bus.req_data = {16'h2222, 16'h1111};
    for (int k = 0; k < 5; k++) begin
      goto(at[k]);
      n_checks++;
      if (bus.gnt !== exp_g[k]) $display("FAIL rr_gnt_%0d: got %b expected %b", k, bus.gnt, exp_g[k]);
      else n_pass++;
      if (k == 1) begin
        read_word(256, w);
        n_checks++;
        if (w !== 16'h1111) $display("FAIL rr_frame0: got %h expected 1111", w);
        else n_pass++;
      end
      if (k == 2) begin
        read_word(384, w);
        n_checks++;
        if (w !== 16'h2222) $display("FAIL rr_frame1: got %h expected 2222", w);
        else n_pass++;
      end
    end
    bus.req = 2'b00;
  endtask

  task automatic test_rx_nav();
    int valids = 0;
    goto(768);
    set_pat(16'h1F00);
    goto(895);
    n_checks++;
    if (rx_valid !== 1'b0) $display("FAIL rx_valid_early: got %b expected 0", rx_valid);
    else n_pass++;
    step();
    n_checks++;
    if ({rx_valid, rx_frame} !== {1'b1, 16'h1F00}) $display("FAIL rx_frame: got %b/%h expected 1/1f00", rx_valid, rx_frame);
    else n_pass++;
    n_checks++;
    if (nav !== 5'b00000) $display("FAIL nav_before: got %b expected 00000", nav);
    else n_pass++;
    step();
`ifdef NAV_DEBOUNCE_EN
    n_checks++;
    if (nav !== 5'b00000) $display("FAIL nav_first_frame: got %b expected 00000", nav);
    else n_pass++;
`else
    n_checks++;
    if (nav !== 5'b11111) $display("FAIL nav_first_frame: got %b expected 11111", nav);
    else n_pass++;
`endif
    for (int i = 0; i < 128; i++) begin
      step();
      if (rx_valid === 1'b1) valids++;
    end
    n_checks++;
    if (valids !== 1) $display("FAIL rx_valid_per_frame: got %0d expected 1", valids);
    else n_pass++;
    goto(1152);
`ifdef NAV_DEBOUNCE_EN
    n_checks++;
    if (nav !== 5'b00000) $display("FAIL nav_before_third: got %b expected 00000", nav);
    else n_pass++;
`endif
    step();
    n_checks++;
    if (nav !== 5'b11111) $display("FAIL nav_settled: got %b expected 11111", nav);
    else n_pass++;
  endtask

  task automatic test_nav_glitch();
    goto(1280);
    set_pat(16'h1E00);
    goto(1408);
    set_pat(16'h1F00);
    n_checks++;
    if (rx_frame !== 16'h1E00) $display("FAIL glitch_rx_frame: got %h expected 1e00", rx_frame);
    else n_pass++;
    goto(1409);
`ifdef NAV_DEBOUNCE_EN
    n_checks++;
    if (nav !== 5'b11111) $display("FAIL glitch_nav: got %b expected 11111", nav);
    else n_pass++;
`else
    n_checks++;
    if (nav !== 5'b11110) $display("FAIL glitch_nav: got %b expected 11110", nav);
    else n_pass++;
`endif
    goto(1537);
    n_checks++;
    if (nav !== 5'b11111) $display("FAIL glitch_recover: got %b expected 11111", nav);
    else n_pass++;
    goto(1664);
    set_pat(16'h1E00);
    goto(1793);
`ifdef NAV_DEBOUNCE_EN
    n_checks++;
    if (nav !== 5'b11111) $display("FAIL hold_nav_1: got %b expected 11111", nav);
    else n_pass++;
`else
    n_checks++;
    if (nav !== 5'b11110) $display("FAIL hold_nav_1: got %b expected 11110", nav);
    else n_pass++;
`endif
    goto(2049);
    n_checks++;
    if (nav !== 5'b11110) $display("FAIL hold_nav_3: got %b expected 11110", nav);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int gc = -1;
    logic [1:0] gv = 2'b00;
    logic [15:0] w;
    bus.req = 2'b01;
    bus.req_data = {16'h0000, 16'hFFFF};
    for (int i = 0; i < 200 && gc < 0; i++) begin
      step();
      if (bus.gnt !== 2'b00) gc = cyc;
    end
    bus.req = 2'b00;
    goto(2176 + 7*8 + 3);
    n_checks++;
    if ({mosi, nav} !== {1'b1, 5'b11110}) $display("FAIL pre_reset: got %b/%b expected 1/11110", mosi, nav);
    else n_pass++;
    rst = 1'b1;
    step();
    n_checks++;
    if ({mosi, cclk, load, bus.gnt, rx_valid} !== 6'b0) $display("FAIL mid_reset_pins: got %b expected 000000", {mosi, cclk, load, bus.gnt, rx_valid});
    else n_pass++;
    n_checks++;
    if ({rx_frame, nav} !== 21'h0) $display("FAIL mid_reset_rx_nav: got %h expected 0", {rx_frame, nav});
    else n_pass++;
    bus.req = 2'b11;
    bus.req_data = {16'h5678, 16'h1234};
    rst = 1'b0;
    cyc = 0;
    miso = miso_pat[0];
    gc = -1;
    for (int i = 0; i < 400 && gc < 0; i++) begin
      step();
      if (bus.gnt !== 2'b00) begin
        gc = cyc;
        gv = bus.gnt;
      end
    end
    n_checks++;
    if (gc !== 256) $display("FAIL post_reset_first_gnt_cycle: got %0d expected 256", gc);
    else n_pass++;
    n_checks++;
    if (gv !== 2'b01) $display("FAIL post_reset_first_gnt: got %b expected 01", gv);
    else n_pass++;
    read_word(256, w);
    n_checks++;
    if (w !== 16'h1234) $display("FAIL post_reset_frame: got %h expected 1234", w);
    else n_pass++;
    bus.req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_grant();
    test_round_robin();
    test_rx_nav();
    test_nav_glitch();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
